// File: rtl/door_round_controller.sv
// Round sequencer for the door game: LFSR door pick, per-round countdown, reveal, lives and score.
// Optional feature: define DOOR_SCORE_EN to build the saturating score register (otherwise score is 0).
module door_round_controller #(
  parameter int          CLK_HZ         = 25_000_000,
  parameter int          ROUND_SECONDS  = 10,
  parameter int          REVEAL_SECONDS = 3,
  parameter int          LIVES          = 3,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [1:0] sel_door,
  output logic [1:0] correct_door,
  output logic       time_up,
  output logic [3:0] seconds_left,
  output logic [1:0] lives,
  output logic       round_win,
  output logic       game_over,
  output logic       busy,
  output logic [7:0] score
);

  // state       | meaning
  // S_IDLE      | waiting for start after reset
  // S_ARM       | one cycle: latch winning door, load countdown
  // S_COUNTDOWN | seconds ticking, waiting for a door press
  // S_REVEAL    | open door shown for REVEAL_SECONDS
  // S_GAME_OVER | no lives left, waiting for start
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNTDOWN,
    S_REVEAL,
    S_GAME_OVER
  } state_t;

  localparam int             PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [7:0]     SEED_SAFE   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0]     ROUND_INIT  = 4'(ROUND_SECONDS);
  localparam logic [3:0]     REVEAL_INIT = 4'(REVEAL_SECONDS);
  localparam logic [1:0]     LIVES_INIT  = 2'(LIVES);

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    lfsr;
  logic [3:0]    reveal_cnt;
  logic          sec_tick;
  logic          lfsr_fb;
  logic          win_now;
  logic          round_end;

  assign sec_tick  = (presc == PRESC_MAX);
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign win_now   = sel_valid && (sel_door == correct_door);
  // a press in the same cycle as the final tick still counts as the player's choice
  assign round_end = sel_valid || (sec_tick && (seconds_left <= 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      presc        <= '0;
      lfsr         <= SEED_SAFE;
      reveal_cnt   <= '0;
      correct_door <= 2'd0;
      time_up      <= 1'b0;
      seconds_left <= 4'd0;
      lives        <= LIVES_INIT;
      round_win    <= 1'b0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr_fb};
      presc <= sec_tick ? '0 : presc + 1'b1;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            state     <= S_ARM;
            lives     <= LIVES_INIT;
            busy      <= 1'b1;
            game_over <= 1'b0;
          end
        end
        S_ARM: begin
          correct_door <= lfsr[1:0];
          seconds_left <= ROUND_INIT;
          presc        <= '0;
          state        <= S_COUNTDOWN;
        end
        S_COUNTDOWN: begin
          if (sec_tick) seconds_left <= seconds_left - 4'd1;
          if (round_end) begin
            state      <= S_REVEAL;
            presc      <= '0;
            reveal_cnt <= REVEAL_INIT;
            time_up    <= 1'b1;
            round_win  <= win_now;
            if (!win_now && (lives != 2'd0)) lives <= lives - 2'd1;
          end
        end
        S_REVEAL: begin
          if (sec_tick) begin
            if (reveal_cnt <= 4'd1) begin
              time_up   <= 1'b0;
              round_win <= 1'b0;
              if (lives == 2'd0) begin
                state     <= S_GAME_OVER;
                game_over <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state <= S_ARM;
              end
            end else begin
              reveal_cnt <= reveal_cnt - 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DOOR_SCORE_EN
  logic [7:0] score_q;
  logic       game_start;

  assign game_start = start && ((state == S_IDLE) || (state == S_GAME_OVER));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q <= 8'd0;
    end else if (game_start) begin
      score_q <= 8'd0;
    end else if ((state == S_COUNTDOWN) && win_now && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule
